// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle of the data-memory arbiter: one command channel plus
// its grant and response.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        wmask;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wdata, wmask,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wmask,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the core (m0) and the loader (m1):
// registered round-robin grant, m1 starvation guard, in-order 1-deep responses.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic              m0_stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wmask,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic {PORT_M0 = 1'b0, PORT_M1 = 1'b1} port_e;

  port_e             r_last;
  logic [3:0]        r_starve;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_en;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wmask;
  port_e             r_cmd_port;
  logic              r_rsp_vld;
  logic              r_rsp_rd;
  port_e             r_rsp_port;
  logic [31:0]       r_rdata0;
  logic [31:0]       r_rdata1;

  logic w_m0_elig;
  logic w_m1_elig;
  logic w_starved;
  logic w_sel0;
  logic w_sel1;
  logic w_ld0;
  logic w_ld1;

  // A port whose grant is showing this cycle already had its command taken.
  assign w_m0_elig = m0.req & ~r_gnt0;
  assign w_m1_elig = m1.req & ~r_gnt1;
  assign w_starved = (r_starve >= 4'(STARVE_LIM));

  always_comb begin
    w_sel0 = 1'b0;
    w_sel1 = 1'b0;
    if (w_m0_elig && w_m1_elig) begin
      if (w_starved || (r_last == PORT_M0)) w_sel1 = 1'b1;
      else                                  w_sel0 = 1'b1;
    end else if (w_m0_elig) begin
      w_sel0 = 1'b1;
    end else if (w_m1_elig) begin
      w_sel1 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last     <= PORT_M1;
      r_starve   <= 4'd0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_en       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_wmask    <= 4'd0;
      r_cmd_port <= PORT_M0;
    end else begin
      r_gnt0 <= w_sel0;
      r_gnt1 <= w_sel1;
      r_en   <= w_sel0 | w_sel1;
      if (w_sel0) begin
        r_last     <= PORT_M0;
        r_we       <= m0.we;
        r_addr     <= m0.addr;
        r_wdata    <= m0.wdata;
        r_wmask    <= m0.wmask;
        r_cmd_port <= PORT_M0;
      end else if (w_sel1) begin
        r_last     <= PORT_M1;
        r_we       <= m1.we;
        r_addr     <= m1.addr;
        r_wdata    <= m1.wdata;
        r_wmask    <= m1.wmask;
        r_cmd_port <= PORT_M1;
      end else begin
        r_we       <= 1'b0;
        r_addr     <= '0;
        r_wdata    <= 32'd0;
        r_wmask    <= 4'd0;
        r_cmd_port <= PORT_M0;
      end
      if (w_sel1 || !m1.req)                r_starve <= 4'd0;
      else if (w_sel0 && r_starve != 4'hF)  r_starve <= r_starve + 4'd1;
    end
  end

  // Response stage: the tag follows the command by one cycle, RAM data lands alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_vld  <= 1'b0;
      r_rsp_rd   <= 1'b0;
      r_rsp_port <= PORT_M0;
      r_rdata0   <= 32'd0;
      r_rdata1   <= 32'd0;
    end else begin
      r_rsp_vld  <= r_en;
      r_rsp_rd   <= r_en & ~r_we;
      r_rsp_port <= r_cmd_port;
      if (w_ld0) r_rdata0 <= ram_rdata;
      if (w_ld1) r_rdata1 <= ram_rdata;
    end
  end

  assign w_ld0 = r_rsp_vld & r_rsp_rd & (r_rsp_port == PORT_M0);
  assign w_ld1 = r_rsp_vld & r_rsp_rd & (r_rsp_port == PORT_M1);

  assign m0.gnt    = r_gnt0;
  assign m1.gnt    = r_gnt1;
  assign m0.rvalid = r_rsp_vld & (r_rsp_port == PORT_M0);
  assign m1.rvalid = r_rsp_vld & (r_rsp_port == PORT_M1);
  assign m0.rdata  = w_ld0 ? ram_rdata : r_rdata0;
  assign m1.rdata  = w_ld1 ? ram_rdata : r_rdata1;
  assign m0_stall  = m0.req & ~r_gnt0;

  assign ram_en    = r_en;
  assign ram_we    = r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign ram_wmask = r_wmask;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: reset, directed vector table, starvation/reset corner
// sequences, then randomized traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LIM    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) m0_if ();
  dmem_arbiter_if #(.ADDR_W(ADDR_W)) m1_if ();
  logic        m0_stall, ram_en, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_wmask;

  dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .m0_stall(m0_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] init_word(input logic [7:0] i);
    if (i == 8'd1) return 32'h1111_1111;
    if (i == 8'd4) return 32'hDEAD_BEEF;
    return {8'hA0, i, ~i, 8'h5C};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  // RAM model: synchronous read, data valid the cycle after the command; garbage otherwise.
  logic [31:0] mem [256];
  bit          mem_wr [256];
  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      mem[ram_addr[9:2]]    <= merge(mem_wr[ram_addr[9:2]] ? mem[ram_addr[9:2]] : init_word(ram_addr[9:2]), ram_wdata, ram_wmask);
      mem_wr[ram_addr[9:2]] <= 1'b1;
    end
    if (ram_en && !ram_we) ram_rdata <= mem_wr[ram_addr[9:2]] ? mem[ram_addr[9:2]] : init_word(ram_addr[9:2]);
    else                   ram_rdata <= $urandom;
  end

  // Requesters may not change a waiting command.
  logic [68:0] f0_prev, f1_prev;
  logic        r0_prev = 1'b0, r1_prev = 1'b0;
  always @(posedge clk) begin
    if (rst && r0_prev && m0_if.req && !m0_if.gnt)
      assert ({m0_if.we, m0_if.addr, m0_if.wdata, m0_if.wmask} == f0_prev) else $error("m0 fields changed while waiting");
    if (rst && r1_prev && m1_if.req && !m1_if.gnt)
      assert ({m1_if.we, m1_if.addr, m1_if.wdata, m1_if.wmask} == f1_prev) else $error("m1 fields changed while waiting");
    r0_prev <= m0_if.req;
    r1_prev <= m1_if.req;
    f0_prev <= {m0_if.we, m0_if.addr, m0_if.wdata, m0_if.wmask};
    f1_prev <= {m1_if.we, m1_if.addr, m1_if.wdata, m1_if.wmask};
  end

  int total = 0;
  int bad   = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic        rq_req [2];
  logic        rq_we [2];
  logic [31:0] rq_addr [2];
  logic [31:0] rq_wdata [2];
  logic [3:0]  rq_wmask [2];

  task automatic drive_all();
    m0_if.req = rq_req[0]; m0_if.we = rq_we[0]; m0_if.addr = rq_addr[0];
    m0_if.wdata = rq_wdata[0]; m0_if.wmask = rq_wmask[0];
    m1_if.req = rq_req[1]; m1_if.we = rq_we[1]; m1_if.addr = rq_addr[1];
    m1_if.wdata = rq_wdata[1]; m1_if.wmask = rq_wmask[1];
  endtask

  task automatic set_cmd(input int p, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    rq_req[p] = 1'b1; rq_we[p] = we; rq_addr[p] = a; rq_wdata[p] = d; rq_wmask[p] = m;
  endtask

  task automatic rnd_cmd(input int p);
    set_cmd(p, 1'($urandom_range(0, 1)), 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2),
            $urandom, 4'($urandom_range(0, 15)));
  endtask

  // Reference model: memory image plus the arbitration rules, stepped once per clock.
  logic [31:0] ref_mem [256];
  bit          ref_wr [256];
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_wr[a[9:2]] ? ref_mem[a[9:2]] : init_word(a[9:2]);
  endfunction
  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    ref_mem[a[9:2]] = merge(ref_read(a), d, m);
    ref_wr[a[9:2]]  = 1'b1;
  endtask

  int          mdl_last, mdl_starve, pend_p;
  bit          mdl_g [2];
  bit          pend_v, pend_rd;
  logic [31:0] pend_d;
  logic [31:0] mdl_rdata [2];
  bit          e_en, e_we;
  bit          e_rv [2];
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wmask;

  task automatic mdl_reset();
    mdl_last = 1; mdl_starve = 0; pend_v = 0; pend_rd = 0; pend_p = 0; pend_d = 0;
    for (int p = 0; p < 2; p++) begin mdl_g[p] = 0; mdl_rdata[p] = 0; e_rv[p] = 0; end
    e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_wmask = 0;
  endtask

  task automatic mdl_step();
    bit e0, e1;
    int w;
    e0 = rq_req[0] && !mdl_g[0];
    e1 = rq_req[1] && !mdl_g[1];
    w  = -1;
    if (e0 && e1)  w = (mdl_starve >= LIM) ? 1 : ((mdl_last == 0) ? 1 : 0);
    else if (e0)   w = 0;
    else if (e1)   w = 1;
    e_rv[0] = 0; e_rv[1] = 0;
    if (pend_v) begin
      e_rv[pend_p] = 1;
      if (pend_rd) mdl_rdata[pend_p] = pend_d;
    end
    mdl_g[0] = (w == 0);
    mdl_g[1] = (w == 1);
    pend_v = (w >= 0);
    if (w >= 0) begin
      e_en = 1; e_we = rq_we[w]; e_addr = rq_addr[w]; e_wdata = rq_wdata[w]; e_wmask = rq_wmask[w];
      pend_p = w; pend_rd = !rq_we[w];
      if (pend_rd) pend_d = ref_read(rq_addr[w]);
      else         ref_write(rq_addr[w], rq_wdata[w], rq_wmask[w]);
      mdl_last = w;
    end else begin
      e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_wmask = 0;
    end
    if (w == 1 || !rq_req[1]) mdl_starve = 0;
    else if (w == 0)          mdl_starve = (mdl_starve < 15) ? mdl_starve + 1 : 15;
  endtask

  task automatic mdl_check(input string t);
    chk({t, ".m0_gnt"},    m0_if.gnt,    mdl_g[0]);
    chk({t, ".m1_gnt"},    m1_if.gnt,    mdl_g[1]);
    chk({t, ".ram_en"},    ram_en,       e_en);
    chk({t, ".ram_we"},    ram_we,       e_we);
    chk({t, ".ram_addr"},  ram_addr,     e_addr);
    chk({t, ".ram_wdata"}, ram_wdata,    e_wdata);
    chk({t, ".ram_wmask"}, ram_wmask,    e_wmask);
    chk({t, ".m0_rvalid"}, m0_if.rvalid, e_rv[0]);
    chk({t, ".m1_rvalid"}, m1_if.rvalid, e_rv[1]);
    chk({t, ".m0_rdata"},  m0_if.rdata,  mdl_rdata[0]);
    chk({t, ".m1_rdata"},  m1_if.rdata,  mdl_rdata[1]);
    chk({t, ".m0_stall"},  m0_stall,     rq_req[0] & ~mdl_g[0]);
  endtask

  // mode 0: drain, 1: both ports always busy, 2: random traffic
  task automatic cyc(input int mode, input string t);
    @(negedge clk);
    mdl_check(t);
    for (int p = 0; p < 2; p++) begin
      if (mdl_g[p] || !rq_req[p]) begin
        case (mode)
          1:       rnd_cmd(p);
          2:       if ($urandom_range(0, 3) != 0) rnd_cmd(p); else rq_req[p] = 1'b0;
          default: rq_req[p] = 1'b0;
        endcase
      end
    end
    drive_all();
    mdl_step();
  endtask

  task automatic chk_zero(input string t);
    chk({t, ".m0_gnt"},    m0_if.gnt,    0);
    chk({t, ".m1_gnt"},    m1_if.gnt,    0);
    chk({t, ".m0_rvalid"}, m0_if.rvalid, 0);
    chk({t, ".m1_rvalid"}, m1_if.rvalid, 0);
    chk({t, ".m0_rdata"},  m0_if.rdata,  0);
    chk({t, ".m1_rdata"},  m1_if.rdata,  0);
    chk({t, ".ram_en"},    ram_en,       0);
    chk({t, ".ram_we"},    ram_we,       0);
    chk({t, ".ram_addr"},  ram_addr,     0);
    chk({t, ".ram_wdata"}, ram_wdata,    0);
    chk({t, ".ram_wmask"}, ram_wmask,    0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    rq_req[0] = 1'b0; rq_req[1] = 1'b0;
    drive_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    mdl_reset();
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    int   n0, q;
    bit   got;
    tbl[0] = '{0, 1'b0, 32'h8000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    tbl[1] = '{1, 1'b1, 32'h8000_0004, 32'h1234_5678, 4'b0011, 32'h0};
    tbl[2] = '{1, 1'b0, 32'h8000_0004, 32'h0,         4'b0000, 32'h1111_5678};
    tbl[3] = '{0, 1'b1, 32'h8000_0010, 32'hCAFE_F00D, 4'b1100, 32'hDEAD_BEEF};
    tbl[4] = '{0, 1'b0, 32'h8000_0010, 32'h0,         4'b0000, 32'hCAFE_BEEF};
    tbl[5] = '{1, 1'b1, 32'h8000_0000, 32'hAABB_CCDD, 4'b1111, 32'h1111_5678};

    for (int p = 0; p < 2; p++) set_cmd(p, 1'b0, 32'h0, 32'h0, 4'h0);
    rq_req[0] = 1'b0; rq_req[1] = 1'b0;
    drive_all();
    mdl_reset();

    #1 rst = 1'b0;
    set_cmd(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
    drive_all();
    #2;
    chk_zero("reset");
    chk("reset.m0_stall_follows_req", m0_stall, 1);
    @(negedge clk);
    chk("reset.m0_gnt_held", m0_if.gnt, 0);
    chk("reset.ram_en_held", ram_en, 0);
    rq_req[0] = 1'b0;
    drive_all();
    #1 chk("reset.m0_stall_low", m0_stall, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_cmd(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].wmask);
      drive_all();
      #1 chk($sformatf("vec%0d.stall_pending", i), m0_stall, tbl[i].port == 0);
      @(negedge clk);
      chk($sformatf("vec%0d.m0_gnt", i),    m0_if.gnt, tbl[i].port == 0);
      chk($sformatf("vec%0d.m1_gnt", i),    m1_if.gnt, tbl[i].port == 1);
      chk($sformatf("vec%0d.ram_en", i),    ram_en,    1);
      chk($sformatf("vec%0d.ram_we", i),    ram_we,    tbl[i].we);
      chk($sformatf("vec%0d.ram_addr", i),  ram_addr,  tbl[i].addr);
      chk($sformatf("vec%0d.ram_wdata", i), ram_wdata, tbl[i].wdata);
      chk($sformatf("vec%0d.ram_wmask", i), ram_wmask, tbl[i].wmask);
      chk($sformatf("vec%0d.stall_granted", i), m0_stall, 0);
      chk($sformatf("vec%0d.rvalid_early", i), {m0_if.rvalid, m1_if.rvalid}, 0);
      rq_req[tbl[i].port] = 1'b0;
      drive_all();
      if (tbl[i].we) ref_write(tbl[i].addr, tbl[i].wdata, tbl[i].wmask);
      @(negedge clk);
      chk($sformatf("vec%0d.m0_rvalid", i), m0_if.rvalid, tbl[i].port == 0);
      chk($sformatf("vec%0d.m1_rvalid", i), m1_if.rvalid, tbl[i].port == 1);
      chk($sformatf("vec%0d.rdata", i), (tbl[i].port == 0) ? m0_if.rdata : m1_if.rdata, tbl[i].exp_rdata);
      chk($sformatf("vec%0d.ram_idle", i), {ram_en, ram_addr}, 0);
    end

    // Starvation: hold m1 off while m0 keeps issuing, then let it compete.
    do_reset();
    @(negedge clk);
    force dut.w_m1_elig = 1'b0;
    set_cmd(1, 1'b0, 32'h8000_0008, 32'h0, 4'h0);
    set_cmd(0, 1'b0, 32'h8000_000C, 32'h0, 4'h0);
    drive_all();
    n0 = 0;
    for (int k = 0; k < 40 && n0 < 4; k++) begin
      @(negedge clk);
      chk("starve.m1_held_off", m1_if.gnt, 0);
      if (m0_if.gnt) begin
        n0++;
        rq_addr[0] = rq_addr[0] + 32'd4;
        drive_all();
      end
    end
    chk("starve.m0_grants", n0, 4);
    chk("starve.count_at_limit", dut.r_starve, 4);
    release dut.w_m1_elig;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      if (m0_if.gnt || m1_if.gnt) begin
        got = 1'b1;
        chk("starve.m1_wins", m1_if.gnt, 1);
        chk("starve.m0_loses", m0_if.gnt, 0);
        chk("starve.count_cleared", dut.r_starve, 0);
      end
    end
    chk("starve.grant_seen", got, 1);
    rq_req[1] = 1'b0;
    drive_all();
    q = 0;
    for (int k = 0; k < 4 && rq_req[0]; k++) begin
      @(negedge clk);
      if (m0_if.gnt) begin rq_req[0] = 1'b0; drive_all(); end
    end
    chk("starve.m0_drained", rq_req[0], 0);

    // Reset while an m0 load is on the RAM port.
    do_reset();
    @(negedge clk);
    set_cmd(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
    drive_all();
    @(negedge clk);
    chk("rstmid.ram_en_before", ram_en, 1);
    rst = 1'b0;
    rq_req[0] = 1'b0;
    drive_all();
    #1 chk_zero("rstmid");
    @(negedge clk);
    chk("rstmid.no_rvalid_in_reset", m0_if.rvalid, 0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstmid.no_rvalid_after", {m0_if.rvalid, m1_if.rvalid, ram_en}, 0);
    end
    set_cmd(0, 1'b0, 32'h8000_0020, 32'h0, 4'h0);
    set_cmd(1, 1'b0, 32'h8000_0024, 32'h0, 4'h0);
    drive_all();
    @(negedge clk);
    chk("rstmid.first_m0", m0_if.gnt, 1);
    chk("rstmid.first_not_m1", m1_if.gnt, 0);
    rq_req[0] = 1'b0;
    drive_all();
    @(negedge clk);
    chk("rstmid.then_m1", m1_if.gnt, 1);
    rq_req[1] = 1'b0;
    drive_all();

    do_reset();
    for (int k = 0; k < 12; k++) cyc(1, $sformatf("alt%0d", k));
    for (int k = 0; k < 5; k++)  cyc(0, $sformatf("altdrain%0d", k));

    do_reset();
    for (int k = 0; k < 300; k++) cyc(2, $sformatf("rnd%0d", k));
    for (int k = 0; k < 6; k++)   cyc(0, $sformatf("rnddrain%0d", k));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (the DPI RAM used for load/store) between two requesters.
- Port m0 is the core load/store path. Port m1 is the program-loader/debug path, which writes images and reads back results such as the a0 dump.
- Registered round-robin arbitration with a starvation guard, a one-command-per-cycle pipeline, and in-order response routing.
- Sits between the core/loader and the RAM instance.

Parameters:
- ADDR_W, 32, byte-address width on both requester ports and the RAM port.
- STARVE_LIM, 4, consecutive m0 grants allowed while m1 is waiting before m1 is forced; valid range 1–15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- m0_req  in  1  core request; held with its fields until m0_gnt
- m0_we  in  1  1 = store, 0 = load
- m0_addr  in  ADDR_W  byte address
- m0_wdata  in  32  lane-aligned store data
- m0_wmask  in  4  byte-lane mask; ignored on loads
- m0_gnt  out  1  one-cycle pulse: command accepted and issued to RAM
- m0_rvalid  out  1  one-cycle pulse: response for the granted command
- m0_rdata  out  32  read data; valid when m0_rvalid and the command was a load
- m1_req, m1_we, m1_addr, m1_wdata, m1_wmask, m1_gnt, m1_rvalid, m1_rdata: same as m0, for the loader
- m0_stall  out  1  combinational: m0_req & ~m0_gnt; drives the core PC hold
- ram_en  out  1  RAM command valid
- ram_we  out  1  RAM write
- ram_addr  out  ADDR_W  RAM byte address
- ram_wdata  out  32  RAM write data
- ram_wmask  out  4  RAM byte mask
- ram_rdata  in  32  RAM read data, valid exactly 1 cycle after ram_en & ~ram_we

Behaviour:
- Reset values (async assert): all outputs 0 except combinational m0_stall, which follows m0_req; last-grant pointer = m1 (so m0 wins first); starve counter = 0; response tag pipe empty.
- Arbitration is sampled at cycle t. The winner's gnt and the ram_* command are registered and appear together at t+1 for exactly 1 cycle.
- Both requests asserted, starve counter < STARVE_LIM: the port not granted last wins.
- Starve counter ≥ STARVE_LIM with m1_req asserted: m1 wins.
- Only one request asserted: that port wins, regardless of pointer or counter.
- A requester whose gnt is high at t+1 is not eligible at t+1. Its req at t+1 must be a new command, sampled for t+2 onward.
- Throughput: at most one grant every 2 cycles per port. When both ports are active, grants alternate on consecutive cycles, so the RAM can be busy every cycle.
- Starve counter:
  - increments when m0 is granted while m1_req=1;
  - clears on any m1 grant or when m1_req=0;
  - saturates at 15.
- Response path: a 1-bit valid + port-id + is-read tag travels with each command.
  - At t+2, the tagged port's rvalid pulses for 1 cycle.
  - If the command was a load, that port's rdata = ram_rdata; otherwise rdata holds its previous value.
  - Writes also produce rvalid, used as the write acknowledge.
  - The non-tagged port's rvalid = 0.
- Responses return strictly in grant order. No outstanding limit is needed beyond the 1-deep pipe.
- ram_* fields are 0 when ram_en=0; no stale address is driven.
- Idle (no req): ram_en=0, no gnt, pointer and counter unchanged.
- No combinational path from req to any gnt or ram_* output. m0_stall is the only comb output.
- Reset mid-operation: the in-flight command is dropped, rvalid is not issued after reset, and the RAM sees ram_en=0 from reset assertion on.
- Changing a request's fields while req=1 and before gnt is illegal; the bench asserts on it.
- Write mask is passed through unmodified. Address alignment is the requester's responsibility.

Test Plan:
- Single m0 load: m0_req=1, addr=0x80000010, RAM returns 0xDEADBEEF at t+2.
  → m0_gnt at t+1; ram_en=1, ram_we=0, ram_addr=0x80000010; m0_rvalid=1 and m0_rdata=0xDEADBEEF at t+2; m1_rvalid=0 throughout.
- Single m1 store: addr=0x80000004, wdata=0x12345678, wmask=4'b0011.
  → ram_we=1, ram_wmask=0011, ram_wdata=0x12345678 at t+1; m1_rvalid at t+2; m1_rdata unchanged.
- Simultaneous continuous requests from both ports, STARVE_LIM=4.
  → grants alternate m0, m1, m0, m1 on successive cycles from the first grant; each rvalid arrives 1 cycle after its gnt, to the correct port.
- Starvation: m1_req held; m0 issues back-to-back while m1 is forced ineligible by a bench override.
  → after 4 m0 grants with m1 waiting, the next grant is m1; the counter reads 0 afterwards.
- Reset mid-command: assert rst low in the cycle ram_en=1 (m0 load).
  → all outputs 0 immediately (async); no m0_rvalid after release; the first grant after release goes to m0.
- Stall: m0_req held while m1 is granted.
  → m0_stall=1 in that cycle and drops in the cycle m0_gnt=1.
